// File: rtl/multi_4x4_if.sv
// Operand/result bundle for multi_4x4: the master drives operands, the slave returns the product.
interface multi_4x4_if;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic [7:0] product;

   modport master (output in_valid, output a, output b, input out_valid, input product);
   modport slave  (input in_valid, input a, input b, output out_valid, output product);
endinterface

// File: rtl/multi_4x4.sv
// Unsigned 4x4 array multiplier built from explicit half/full-adder ripple rows, registered 8-bit product.
// Optional feature macro MULTI_4X4_PIPE_EN adds a register stage after reduction row 1 (latency 2).
module multi_4x4 (
   input  logic       clk,
   input  logic       rst,
   multi_4x4_if.slave bus
);

   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

   // One reduction row: LSB is a half adder, upper bits ripple through full adders, bit 4 is carry-out.
   function automatic logic [4:0] ripple_add4(input logic [3:0] x, input logic [3:0] y);
      logic [4:0] r;
      logic [1:0] cs;
      logic       c;
      cs   = half_add(x[0], y[0]);
      r[0] = cs[0];
      c    = cs[1];
      for (int k = 1; k < 4; k++) begin
         cs   = full_add(x[k], y[k], c);
         r[k] = cs[0];
         c    = cs[1];
      end
      r[4] = c;
      return r;
   endfunction

   function automatic logic [3:0] pp_row(input logic [3:0] x, input logic bit_sel);
      return x & {4{bit_sel}};
   endfunction

   logic [3:0] pp0_s;
   logic [3:0] pp1_s;
   logic [4:0] row1_s;
   logic [4:0] row1_use_s;
   logic [4:0] row2_s;
   logic [4:0] row3_s;
   logic [3:0] row23_a_s;
   logic [1:0] row23_b_s;
   logic [1:0] lsb_s;
   logic       cap_vld_s;
   logic [7:0] arr_prod_s;
   logic [7:0] product_d;
   logic [7:0] product_q;
   logic       out_valid_d;
   logic       out_valid_q;

   assign pp0_s  = pp_row(bus.a, bus.b[0]);
   assign pp1_s  = pp_row(bus.a, bus.b[1]);
   assign row1_s = ripple_add4(pp1_s, {1'b0, pp0_s[3:1]});

`ifdef MULTI_4X4_PIPE_EN
   logic [4:0] row1_q;
   logic [1:0] lsb_q;
   logic [1:0] b_hi_q;
   logic [3:0] a_q;
   logic       vld_q;

   // Mid-array stage: row-1 result, settled product bits and the operand bits rows 2/3 still need.
   always_ff @(posedge clk) begin
      if (rst) begin
         row1_q <= 5'd0;
         lsb_q  <= 2'd0;
         b_hi_q <= 2'd0;
         a_q    <= 4'd0;
         vld_q  <= 1'b0;
      end else begin
         row1_q <= row1_s;
         lsb_q  <= {row1_s[0], pp0_s[0]};
         b_hi_q <= bus.b[3:2];
         a_q    <= bus.a;
         vld_q  <= bus.in_valid;
      end
   end

   assign row1_use_s = row1_q;
   assign lsb_s      = lsb_q;
   assign row23_a_s  = a_q;
   assign row23_b_s  = b_hi_q;
   assign cap_vld_s  = vld_q;
`else
   assign row1_use_s = row1_s;
   assign lsb_s      = {row1_s[0], pp0_s[0]};
   assign row23_a_s  = bus.a;
   assign row23_b_s  = bus.b[3:2];
   assign cap_vld_s  = bus.in_valid;
`endif

   // Each later row adds the next partial product to the carry-out and upper sums of the row before.
   assign row2_s     = ripple_add4(pp_row(row23_a_s, row23_b_s[0]), row1_use_s[4:1]);
   assign row3_s     = ripple_add4(pp_row(row23_a_s, row23_b_s[1]), row2_s[4:1]);
   assign arr_prod_s = {row3_s[4:1], row3_s[0], row2_s[0], lsb_s};

   // Output next-state: capture on a valid stage, otherwise hold the last product.
   always_comb begin
      product_d   = product_q;
      out_valid_d = cap_vld_s;
      if (cap_vld_s) begin
         product_d = arr_prod_s;
      end else begin
         product_d = product_q;
      end
   end

   // Output register; reset wins over a valid capture in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         product_q   <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.product   = product_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_multi_4x4.sv
// Directed self-checking bench for multi_4x4; a small delay-line model tracks latency, hold and reset.
module tb_multi_4x4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic       exp_v;
   logic [7:0] exp_p;
`ifdef MULTI_4X4_PIPE_EN
   logic       dl_v;
   logic [7:0] dl_p;
`endif

   multi_4x4_if bus ();

   multi_4x4 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Drive one cycle, advance the expected-output model, then compare after the edge.
   task automatic cycle(input logic r, input logic v, input logic [3:0] xa, input logic [3:0] xb,
                        input logic [7:0] xp, input string tag);
      logic       o_v;
      logic [7:0] o_p;
      rst          = r;
      bus.in_valid = v;
      bus.a        = xa;
      bus.b        = xb;
      @(posedge clk);
      #1;
`ifdef MULTI_4X4_PIPE_EN
      o_v  = dl_v;
      o_p  = dl_p;
      dl_v = v;
      dl_p = xp;
      if (r) begin
         dl_v = 1'b0;
         dl_p = 8'h00;
      end
`else
      o_v = v;
      o_p = xp;
`endif
      if (r) begin
         exp_v = 1'b0;
         exp_p = 8'h00;
      end else begin
         exp_v = o_v;
         if (o_v) exp_p = o_p;
      end
      check_eq({tag, "_vld"}, {7'd0, bus.out_valid}, {7'd0, exp_v});
      check_eq({tag, "_prod"}, bus.product, exp_p);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_v    = 1'b0;
      exp_p    = 8'h00;
`ifdef MULTI_4X4_PIPE_EN
      dl_v = 1'b0;
      dl_p = 8'h00;
`endif
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.a        = 4'h0;
      bus.b        = 4'h0;

      // Reset held with a live 15x15 request; result must appear only after reset drops.
      cycle(1'b1, 1'b1, 4'hF, 4'hF, 8'hE1, "rst0");
      cycle(1'b1, 1'b1, 4'hF, 4'hF, 8'hE1, "rst1");
      cycle(1'b0, 1'b1, 4'hF, 4'hF, 8'hE1, "post_rst");
      cycle(1'b0, 1'b0, 4'h0, 4'h0, 8'h00, "post_rst_idle");
      cycle(1'b0, 1'b0, 4'h0, 4'h0, 8'h00, "post_rst_idle2");

      // Directed stream with a three-cycle hold after 7x7.
      cycle(1'b0, 1'b1, 4'd6, 4'd6, 8'b0010_0100, "m6x6");
      cycle(1'b0, 1'b1, 4'd2, 4'd6, 8'b0000_1100, "m2x6");
      cycle(1'b0, 1'b1, 4'd7, 4'd5, 8'b0010_0011, "m7x5");
      cycle(1'b0, 1'b1, 4'd7, 4'd7, 8'b0011_0001, "m7x7");
      cycle(1'b0, 1'b0, 4'd3, 4'd9, 8'h00, "hold0");
      cycle(1'b0, 1'b0, 4'd12, 4'd1, 8'h00, "hold1");
      cycle(1'b0, 1'b0, 4'd15, 4'd15, 8'h00, "hold2");
      cycle(1'b0, 1'b1, 4'd5, 4'd5, 8'b0001_1001, "m5x5");
      cycle(1'b0, 1'b1, 4'd7, 4'd3, 8'b0001_0101, "m7x3");
      cycle(1'b0, 1'b1, 4'd4, 4'd6, 8'b0001_1000, "m4x6");

      // Boundaries.
      cycle(1'b0, 1'b1, 4'd0, 4'd15, 8'h00, "b0x15");
      cycle(1'b0, 1'b1, 4'd15, 4'd1, 8'h0F, "b15x1");
      cycle(1'b0, 1'b1, 4'd15, 4'd15, 8'hE1, "b15x15");
      cycle(1'b0, 1'b1, 4'd8, 4'd8, 8'h40, "b8x8");

      // Reset between valid pairs discards the in-flight result.
      cycle(1'b0, 1'b1, 4'd3, 4'd5, 8'd15, "pre_mid");
      cycle(1'b1, 1'b1, 4'd9, 4'd9, 8'd81, "mid_rst");
      cycle(1'b0, 1'b1, 4'd6, 4'd7, 8'd42, "after_mid");
      cycle(1'b0, 1'b1, 4'd11, 4'd13, 8'd143, "after_mid2");
      cycle(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, "drain0");
      cycle(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, "drain1");

      // Exhaustive back-to-back sweep.
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            cycle(1'b0, 1'b1, 4'(i), 4'(j), 8'(i * j), "sweep");
         end
      end
      cycle(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, "sweep_drain0");
      cycle(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, "sweep_drain1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
